// File: rtl/muxn_arb_reg.sv
// N-channel valid/ready arbiter feeding a one-entry registered output stage.
// Supports fixed-priority (MODE=0) or round-robin (MODE=1) grant selection.
module muxn_arb_reg #(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 4,
  parameter  int MODE  = 0,
  localparam int SEL_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [SEL_W-1:0] out_sel_reg, out_sel_next;
  logic             out_valid_reg, out_valid_next;
  logic [SEL_W-1:0] rr_ptr_reg, rr_ptr_next;

  logic             load;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             xfer;

  // rst gates load so in_ready stays low while reset is held
  assign load = !rst && !flush && (!out_valid_reg || out_ready);
  assign xfer = load && gnt_valid;

  // Scan from the far end downward so the nearest candidate wins last
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      int idx;
      if (MODE == 1) begin
        idx = int'(rr_ptr_reg) + k;
        if (idx >= NCH) idx = idx - NCH;
      end else begin
        idx = k;
      end
      if (in_valid[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
    assign in_ready[gi] = xfer && (gnt_idx == SEL_W'(gi));
  end

  always_comb begin
    out_data_next  = out_data_reg;
    out_sel_next   = out_sel_reg;
    out_valid_next = out_valid_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (flush) begin
      out_valid_next = 1'b0;
    end else if (xfer) begin
      out_data_next  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_sel_next   = gnt_idx;
      out_valid_next = 1'b1;
      if (MODE == 1) begin
        rr_ptr_next = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
      end
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
    end else begin
      out_data_reg  <= out_data_next;
      out_sel_reg   <= out_sel_next;
      out_valid_reg <= out_valid_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_muxn_arb_reg.sv
// Directed bench for muxn_arb_reg: one fixed-priority and one round-robin instance.
module tb_muxn_arb_reg;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data0, in_data1;
  logic [N-1:0]   in_valid0, in_valid1, in_ready0, in_ready1;
  logic [W-1:0]   out_data0, out_data1;
  logic [1:0]     out_sel0, out_sel1;
  logic           out_valid0, out_valid1, out_ready0, out_ready1, flush0, flush1;

  int checks = 0;
  int errors = 0;

  muxn_arb_reg #(.WIDTH(W), .NCH(N), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .out_data(out_data0), .out_sel(out_sel0),
    .out_valid(out_valid0), .out_ready(out_ready0));

  muxn_arb_reg #(.WIDTH(W), .NCH(N), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_sel(out_sel1),
    .out_valid(out_valid1), .out_ready(out_ready1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush0 = 1'b0; flush1 = 1'b0;
    in_valid0 = '0; in_valid1 = '0;
    out_ready0 = 1'b1; out_ready1 = 1'b1;
    in_data0 = {32'h33, 32'hCC, 32'h11, 32'hAA};
    in_data1 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    tick();
    chk("rst_valid", 32'(out_valid0), 32'd0);
    chk("rst_data", out_data0, 32'h0);
    rst = 1'b0;

    // Fixed priority: ch1 beats ch3, then ch3 once ch1 drops
    in_valid0 = 4'b1010;
    #1 chk("fp_ready_1010", 32'(in_ready0), 32'h2);
    tick();
    chk("fp_valid", 32'(out_valid0), 32'd1);
    chk("fp_data_ch1", out_data0, 32'h11);
    chk("fp_sel_ch1", 32'(out_sel0), 32'd1);
    in_valid0 = 4'b1000;
    #1 chk("fp_ready_1000", 32'(in_ready0), 32'h8);
    tick();
    chk("fp_data_ch3", out_data0, 32'h33);
    chk("fp_sel_ch3", 32'(out_sel0), 32'd3);

    // Backpressure for 3 cycles with ch2 waiting
    out_ready0 = 1'b0;
    in_valid0 = 4'b0100;
    in_data0[2*W +: W] = 32'h22;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready_stall", 32'(in_ready0), 32'h0);
      tick();
      chk("bp_data_hold", out_data0, 32'h33);
      chk("bp_valid_hold", 32'(out_valid0), 32'd1);
    end
    out_ready0 = 1'b1;
    #1 chk("bp_ready_release", 32'(in_ready0), 32'h4);
    tick();
    chk("bp_data_ch2", out_data0, 32'h22);
    chk("bp_sel_ch2", 32'(out_sel0), 32'd2);
    in_valid0 = 4'b0000;
    tick();
    chk("drain_valid", 32'(out_valid0), 32'd0);
    chk("drain_data_hold", out_data0, 32'h22);

    // Flush beats a simultaneous consume and blocks ch0 for one cycle
    in_data0[0 +: W] = 32'h44;
    in_valid0 = 4'b0001;
    tick();
    chk("fl_pre_data", out_data0, 32'h44);
    flush0 = 1'b1;
    in_data0[0 +: W] = 32'h55;
    #1 chk("fl_ready", 32'(in_ready0), 32'h0);
    tick();
    chk("fl_valid", 32'(out_valid0), 32'd0);
    flush0 = 1'b0;
    #1 chk("fl_ready_after", 32'(in_ready0), 32'h1);
    tick();
    chk("fl_data_ch0", out_data0, 32'h55);
    chk("fl_valid_after", 32'(out_valid0), 32'd1);
    in_valid0 = 4'b1111;
    #1 chk("fp_ready_all", 32'(in_ready0), 32'h1);

    // Round-robin with every channel valid: 0,1,2,3,0
    in_valid1 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("rr_ready_%0d", i), 32'(in_ready1), 32'(1 << (i % 4)));
      tick();
      chk($sformatf("rr_sel_%0d", i), 32'(out_sel1), 32'(i % 4));
      chk($sformatf("rr_data_%0d", i), out_data1, 32'hA0 + 32'(i % 4));
    end

    // Wrap: grant ch2 so rr_ptr=3, then only ch0 valid, then rr_ptr must be 1
    in_valid1 = 4'b0100;
    tick();
    chk("wrap_sel_ch2", 32'(out_sel1), 32'd2);
    in_valid1 = 4'b0001;
    #1 chk("wrap_ready_ch0", 32'(in_ready1), 32'h1);
    tick();
    chk("wrap_sel_ch0", 32'(out_sel1), 32'd0);
    in_valid1 = 4'b1111;
    #1 chk("wrap_ptr_is1", 32'(in_ready1), 32'h2);

    // Asynchronous reset mid-cycle while both outputs hold valid data
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid0", 32'(out_valid0), 32'd0);
    chk("arst_data0", out_data0, 32'h0);
    chk("arst_sel1", 32'(out_sel1), 32'd0);
    chk("arst_ready0", 32'(in_ready0), 32'h0);
    chk("arst_ready1", 32'(in_ready1), 32'h0);
    tick();
    rst = 1'b0;
    #1 chk("arst_rrptr0", 32'(in_ready1), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
